fpu_mul_norm_round: RTL and testbench
=====================================

Name: fpu_mul_norm_round

Overview:
- Downstream stage of the radix-16 Booth multiplier in the high-performance FP multiply path.
- Captures the raw mantissa product on the multiplier's valid pulse, together with sign, exponent and special-case information from the unpack stage.
- Normalizes, rounds per the RISC-V rounding mode, handles overflow, underflow and special operands, and packs the IEEE-754 single-precision result and exception flags.
- Multi-cycle FSM; one result per accepted product.

Parameters:
XLEN, 32 (from shared package), width of multiplier operands; product width is 2*XLEN.
MANT_W, 24, mantissa width including hidden bit.
EXP_W, 10, signed width of the internal exponent.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
clk_en_i  in  1  clock enable; when low, all state and outputs hold
product_i  in  2*XLEN  unsigned mantissa product; valid bits are [47:0], upper bits ignored
product_valid_i  in  1  one-cycle pulse from the multiplier's valid output
sign_i  in  1  result sign (XOR of operand signs)
exp_sum_i  in  EXP_W  signed biased exponent sum, ea+eb-127
is_nan_i  in  1  either operand is NaN
is_inf_i  in  1  either operand is infinity
is_zero_i  in  1  either operand is zero
invalid_i  in  1  inf*0 or signalling NaN
rm_i  in  3  rounding mode (RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100)
result_o  out  32  packed IEEE-754 single result
valid_o  out  1  one-cycle result strobe
busy_o  out  1  high in NORMALIZE and ROUND
flags_o  out  5  {invalid, divzero(always 0), overflow, underflow, inexact}

Behaviour:
- Reset is asynchronous: the FSM goes to IDLE and result_o, valid_o, busy_o and flags_o all go to 0. Asserting reset mid-operation discards the operation; no valid_o pulse follows.
- Everything below advances only when clk_en_i=1.
- IDLE or VALID, with product_valid_i=1: capture product_i[47:0], sign_i, exp_sum_i, special flags and rm_i; go to NORMALIZE. Otherwise VALID goes to IDLE.
- NORMALIZE:
  - If p[47]=1: mant=p[46:24], guard=p[23], sticky=|p[22:0], exp=exp_sum+1.
  - Else: mant=p[45:23], guard=p[22], sticky=|p[21:0], exp=exp_sum.
  - Go to ROUND.
- ROUND:
  - Compute increment:
    - RNE: G&(S|lsb)
    - RTZ: 0
    - RDN: sign&(G|S)
    - RUP: ~sign&(G|S)
    - RMM: G
  - Mantissa carry-out (all ones +1) sets mant=0 and exp+1.
  - inexact=G|S.
  - Go to VALID.
- VALID: register result_o and flags_o; valid_o=1 for exactly this cycle.
- Latency: product_valid_i at edge N gives valid_o high in cycle N+3. result_o and flags_o hold until the next VALID.
- product_valid_i during NORMALIZE or ROUND is ignored. Upstream guarantees spacing of 3 or more cycles; the bench asserts this.
- Special-case priority (NaN > inf > zero > normal):
  - NaN: 32'h7FC00000; invalid flag = invalid_i.
  - inf with zero (invalid_i): 32'h7FC00000, invalid=1.
  - inf: {sign, 8'hFF, 0}.
  - zero: {sign, 31'b0}.
  - Special cases raise no inexact, overflow or underflow.
- Overflow, when final exp ≥ 255; sets overflow=1 and inexact=1:
  - RNE and RMM: signed infinity.
  - RTZ: {sign, 8'hFE, 23'h7FFFFF}.
  - RDN: infinity if negative, else maximum finite.
  - RUP: infinity if positive, else maximum finite.
- Underflow, when final exp ≤ 0: flush to {sign, 31'b0}; underflow=1, inexact=1. No subnormal output.
- Reserved rm_i values (101–111) behave as RNE.

Decomposition:
- Shared package:
  - enum rnd_mode_e.
  - FSM enum {IDLE, NORMALIZE, ROUND, VALID}.
  - Constants CANONICAL_NAN=32'h7FC00000, EXP_BIAS=127, EXP_MAX=255.
  - Packed struct fp_flags_s.
- One combinational sub-module, fpu_round_decider: inputs sign, rm, lsb, guard, sticky; output increment. It is reused later by the adder and divider.

Test Plan:
1. product=48'h900000000000, exp_sum=127, sign=0, RNE → valid_o at N+3, result_o=32'h40100000 (2.25), flags=0.
2. product=48'h400000C00000, exp_sum=127, RNE → 32'h3F800002, inexact=1; same stimulus with RTZ → 32'h3F800001, inexact=1.
3. product=48'h900000000000, exp_sum=254, sign=0 → RNE 32'h7F800000 with overflow and inexact; RTZ 32'h7F7FFFFF; sign=1 with RUP → 32'hFF7FFFFF.
4. product=48'h400000000000, exp_sum=0, sign=1 → 32'h80000000, underflow=1, inexact=1.
5. is_nan_i=1 → 32'h7FC00000; is_inf_i=1 and is_zero_i=1 with invalid_i=1 → 32'h7FC00000, invalid=1; is_inf_i alone with sign=1 → 32'hFF800000.
6. Robustness:
   - rst_n_i low during ROUND → outputs 0 immediately, no valid_o.
   - clk_en_i low for 5 cycles in NORMALIZE → valid_o delayed exactly 5 cycles, same result.
   - Back-to-back products 3 cycles apart → both results correct.

Source files
------------

// File: rtl/fpu_mul_norm_round_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_mul_norm_round_pkg
// Description : Shared types and constants for the FP multiply back end:
//               rounding modes, normalize/round FSM encoding, IEEE-754
//               single-precision constants and the exception flag bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_mul_norm_round_pkg;

    // Operand width of the Booth multiplier feeding this stage.
    localparam int XLEN = 32;

    // IEEE-754 single-precision constants.
    localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;
    localparam int          EXP_BIAS      = 127;
    localparam int          EXP_MAX       = 255;

    // RISC-V rounding modes; encodings 101..111 are treated as RNE.
    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rnd_mode_e;

    // Normalize/round FSM state encoding.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_NORMALIZE = 2'd1;
    localparam logic [1:0] ST_ROUND     = 2'd2;
    localparam logic [1:0] ST_VALID     = 2'd3;

    // Exception flags in fflags bit order {NV, DZ, OF, UF, NX}.
    typedef struct packed {
        logic invalid;
        logic divzero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_s;

endpackage
`default_nettype wire

// File: rtl/fpu_round_decider.sv
`default_nettype none
// ============================================================================
// Module      : fpu_round_decider
// Description : Decides whether a truncated mantissa must be incremented,
//               given sign, rounding mode, LSB, guard and sticky bits.
//               Shared by the multiplier, adder and divider back ends.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_round_decider
    import fpu_mul_norm_round_pkg::*;
(
    input  logic       i_sign,
    input  logic [2:0] i_rm,
    input  logic       i_lsb,
    input  logic       i_guard,
    input  logic       i_sticky,
    output logic       o_increment
);

    // Increment rule per rounding mode; unknown encodings fall back to RNE.
    always_comb begin
        o_increment = i_guard & (i_sticky | i_lsb);
        case (i_rm)
            RM_RTZ:  o_increment = 1'b0;
            RM_RDN:  o_increment = i_sign & (i_guard | i_sticky);
            RM_RUP:  o_increment = ~i_sign & (i_guard | i_sticky);
            RM_RMM:  o_increment = i_guard;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fpu_mul_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : fpu_mul_norm_round
// Description : Back end of the FP multiply path. Captures the raw mantissa
//               product, normalizes, rounds, resolves overflow, underflow
//               and special operands, then packs an IEEE-754 single result
//               with its exception flags. One result per accepted product.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_mul_norm_round
    import fpu_mul_norm_round_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clk_en_i,
    input  logic [2*XLEN-1:0] product_i,
    input  logic              product_valid_i,
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_sum_i,
    input  logic              is_nan_i,
    input  logic              is_inf_i,
    input  logic              is_zero_i,
    input  logic              invalid_i,
    input  logic [2:0]        rm_i,
    output logic [31:0]       result_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic [4:0]        flags_o
);

    localparam int c_FRAC_W = MANT_W - 1;      // stored fraction bits
    localparam int c_PTOP   = 2 * MANT_W - 1;  // MSB of the meaningful product

    // FSM state
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_capture;

    // Captured operation
    logic [c_PTOP:0]         r_prod;
    logic                    r_sign;
    logic signed [EXP_W:0]   r_exp;    // one extra bit absorbs the +1 steps
    logic                    r_nan;
    logic                    r_inf;
    logic                    r_zero;
    logic                    r_inv;
    logic [2:0]              r_rm;

    // Normalized mantissa
    logic [c_FRAC_W-1:0]     r_frac;
    logic                    r_guard;
    logic                    r_sticky;
    logic                    w_top;
    logic [c_FRAC_W-1:0]     w_frac_n;
    logic                    w_guard_n;
    logic                    w_sticky_n;

    // Rounding
    logic                    w_inc;
    logic [c_FRAC_W:0]       w_frac_sum;
    logic signed [EXP_W:0]   w_exp_fin;
    logic                    w_ovf_inf;
    logic [31:0]             w_result;
    fp_flags_s               w_flags;

    // Output registers
    logic [31:0]             r_result;
    fp_flags_s               r_flags;
    logic                    r_valid;

    // Upper product bits are beyond the 24x24 mantissa product.
    logic w_unused;
    assign w_unused = ^product_i[2*XLEN-1:c_PTOP+1];

    assign w_capture = product_valid_i &&
                       ((r_state == ST_IDLE) || (r_state == ST_VALID));

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else if (clk_en_i) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a new product may be accepted straight out of VALID.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (product_valid_i) w_state_nxt = ST_NORMALIZE;
            ST_NORMALIZE: w_state_nxt = ST_ROUND;
            ST_ROUND:     w_state_nxt = ST_VALID;
            ST_VALID:     w_state_nxt = product_valid_i ? ST_NORMALIZE : ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Normalization: product is in [1,4); pick the window below the leading one.
    assign w_top = r_prod[c_PTOP];
    always_comb begin
        if (w_top) begin
            w_frac_n   = r_prod[c_PTOP-1 -: c_FRAC_W];
            w_guard_n  = r_prod[c_PTOP-1-c_FRAC_W];
            w_sticky_n = |r_prod[c_PTOP-2-c_FRAC_W:0];
        end else begin
            w_frac_n   = r_prod[c_PTOP-2 -: c_FRAC_W];
            w_guard_n  = r_prod[c_PTOP-2-c_FRAC_W];
            w_sticky_n = |r_prod[c_PTOP-3-c_FRAC_W:0];
        end
    end

    fpu_round_decider u_round_decider (
        .i_sign      (r_sign),
        .i_rm        (r_rm),
        .i_lsb       (r_frac[0]),
        .i_guard     (r_guard),
        .i_sticky    (r_sticky),
        .o_increment (w_inc)
    );

    // A carry out of the fraction wraps it to zero and bumps the exponent.
    assign w_frac_sum = {1'b0, r_frac} + {{c_FRAC_W{1'b0}}, w_inc};
    assign w_exp_fin  = r_exp + {{EXP_W{1'b0}}, w_frac_sum[c_FRAC_W]};

    // Overflow saturates to infinity unless the mode rounds toward zero.
    always_comb begin
        w_ovf_inf = 1'b1;
        case (r_rm)
            RM_RTZ:  w_ovf_inf = 1'b0;
            RM_RDN:  w_ovf_inf = r_sign;
            RM_RUP:  w_ovf_inf = ~r_sign;
            default: ;
        endcase
    end

    // Result packing with special-operand priority NaN > inf > zero > normal.
    always_comb begin
        w_result = 32'h0;
        w_flags  = '0;
        if (r_nan) begin
            w_result        = CANONICAL_NAN;
            w_flags.invalid = r_inv;
        end else if (r_inf && (r_zero || r_inv)) begin
            w_result        = CANONICAL_NAN;
            w_flags.invalid = 1'b1;
        end else if (r_inf) begin
            w_result = {r_sign, 8'hFF, 23'h0};
        end else if (r_zero) begin
            w_result = {r_sign, 31'h0};
        end else if (w_exp_fin >= EXP_MAX) begin
            w_result         = w_ovf_inf ? {r_sign, 8'hFF, 23'h0}
                                         : {r_sign, 8'hFE, 23'h7F_FFFF};
            w_flags.overflow = 1'b1;
            w_flags.inexact  = 1'b1;
        end else if (w_exp_fin <= 0) begin
            w_result          = {r_sign, 31'h0};
            w_flags.underflow = 1'b1;
            w_flags.inexact   = 1'b1;
        end else begin
            w_result        = {r_sign, w_exp_fin[7:0], w_frac_sum[c_FRAC_W-1:0]};
            w_flags.inexact = r_guard | r_sticky;
        end
    end

    // Datapath and output registers; every stage holds while clk_en_i is low.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_prod   <= '0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_nan    <= 1'b0;
            r_inf    <= 1'b0;
            r_zero   <= 1'b0;
            r_inv    <= 1'b0;
            r_rm     <= 3'b000;
            r_frac   <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_result <= 32'h0;
            r_flags  <= '0;
            r_valid  <= 1'b0;
        end else if (clk_en_i) begin
            if (w_capture) begin
                r_prod <= product_i[c_PTOP:0];
                r_sign <= sign_i;
                r_exp  <= {exp_sum_i[EXP_W-1], exp_sum_i};
                r_nan  <= is_nan_i;
                r_inf  <= is_inf_i;
                r_zero <= is_zero_i;
                r_inv  <= invalid_i;
                r_rm   <= rm_i;
            end
            if (r_state == ST_NORMALIZE) begin
                r_frac   <= w_frac_n;
                r_guard  <= w_guard_n;
                r_sticky <= w_sticky_n;
                r_exp    <= r_exp + {{EXP_W{1'b0}}, w_top};
            end
            if (r_state == ST_ROUND) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
            r_valid <= (r_state == ST_ROUND);
        end
    end

    assign result_o = r_result;
    assign flags_o  = r_flags;
    assign valid_o  = r_valid;
    assign busy_o   = (r_state == ST_NORMALIZE) || (r_state == ST_ROUND);

endmodule
`default_nettype wire

// File: tb/tb_fpu_mul_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_mul_norm_round
// Description : Directed self-checking bench for fpu_mul_norm_round with a
//               scoreboard queue and an independent output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_mul_norm_round;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        clk_en_i = 1'b1;
    logic [63:0] product_i = '0;
    logic        product_valid_i = 1'b0;
    logic        sign_i = 1'b0;
    logic [9:0]  exp_sum_i = '0;
    logic        is_nan_i = 1'b0;
    logic        is_inf_i = 1'b0;
    logic        is_zero_i = 1'b0;
    logic        invalid_i = 1'b0;
    logic [2:0]  rm_i = 3'b000;
    logic [31:0] result_o;
    logic        valid_o;
    logic        busy_o;
    logic [4:0]  flags_o;

    fpu_mul_norm_round dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .clk_en_i        (clk_en_i),
        .product_i       (product_i),
        .product_valid_i (product_valid_i),
        .sign_i          (sign_i),
        .exp_sum_i       (exp_sum_i),
        .is_nan_i        (is_nan_i),
        .is_inf_i        (is_inf_i),
        .is_zero_i       (is_zero_i),
        .invalid_i       (invalid_i),
        .rm_i            (rm_i),
        .result_o        (result_o),
        .valid_o         (valid_o),
        .busy_o          (busy_o),
        .flags_o         (flags_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [4:0]  flg;
        int          due;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Upstream must space products at least 3 cycles apart.
    int last_pv = -100;
    always @(posedge clk_i) begin
        if (rst_n_i && clk_en_i && product_valid_i) begin
            assert (cyc - last_pv >= 3) else $error("product_valid_i spacing violated");
            last_pv <= cyc;
        end
    end

    // Monitor: pop and compare on every result strobe; flag late results.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (valid_o) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid: got result=%h flags=%b at cyc %0d, want no strobe",
                             result_o, flags_o, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (result_o !== e.res || flags_o !== e.flg || cyc != e.due) begin
                        bad++;
                        $display("FAIL %s: got result=%h flags=%b cyc=%0d, want result=%h flags=%b cyc=%0d",
                                 e.name, result_o, flags_o, cyc, e.res, e.flg, e.due);
                    end
                end
            end else if (q.size() > 0 && cyc > q[0].due) begin
                exp_t e;
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL %s: no strobe by cyc %0d, want result=%h flags=%b at cyc %0d",
                         e.name, cyc, e.res, e.flg, e.due);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Drive one product for one cycle; spc = {nan, inf, zero, invalid}.
    task automatic issue(input string name, input logic [47:0] p, input logic [9:0] e,
                         input logic s, input logic [2:0] rm, input logic [3:0] spc,
                         input logic [31:0] xr, input logic [4:0] xf,
                         input int dly, input bit push);
        @(negedge clk_i);
        product_i       = {16'hDEAD, p};
        exp_sum_i       = e;
        sign_i          = s;
        rm_i            = rm;
        {is_nan_i, is_inf_i, is_zero_i, invalid_i} = spc;
        product_valid_i = 1'b1;
        if (push) q.push_back('{name, xr, xf, cyc + 3 + dly});
        @(negedge clk_i);
        product_valid_i = 1'b0;
        {is_nan_i, is_inf_i, is_zero_i, invalid_i} = 4'b0000;
        product_i       = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() != 0 || busy_o); i++) @(negedge clk_i);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk("reset_result", result_o, 32'h0);
        chk("reset_ctrl", {29'h0, valid_o, busy_o, 1'b0}, 32'h0);
        chk("reset_flags", {27'h0, flags_o}, 32'h0);
        rst_n_i = 1'b1;

        // Normal products and rounding modes
        issue("t1_2p25",     48'h9000_0000_0000, 10'd127, 1'b0, 3'b000, 4'b0000, 32'h4010_0000, 5'b00000, 0, 1); drain();
        issue("t2_rne",      48'h4000_00C0_0000, 10'd127, 1'b0, 3'b000, 4'b0000, 32'h3F80_0002, 5'b00001, 0, 1); drain();
        issue("t2_rtz",      48'h4000_00C0_0000, 10'd127, 1'b0, 3'b001, 4'b0000, 32'h3F80_0001, 5'b00001, 0, 1); drain();
        issue("rmm_tie",     48'h4000_0040_0000, 10'd127, 1'b0, 3'b100, 4'b0000, 32'h3F80_0001, 5'b00001, 0, 1); drain();
        issue("rsv_as_rne",  48'h4000_0040_0000, 10'd127, 1'b0, 3'b101, 4'b0000, 32'h3F80_0000, 5'b00001, 0, 1); drain();
        issue("rdn_neg",     48'h4000_0000_0001, 10'd127, 1'b1, 3'b010, 4'b0000, 32'hBF80_0001, 5'b00001, 0, 1); drain();
        issue("carry_out",   48'h7FFF_FFC0_0000, 10'd127, 1'b0, 3'b000, 4'b0000, 32'h4000_0000, 5'b00001, 0, 1); drain();

        // Overflow and underflow
        issue("ovf_rne",     48'h9000_0000_0000, 10'd254, 1'b0, 3'b000, 4'b0000, 32'h7F80_0000, 5'b00101, 0, 1); drain();
        issue("ovf_rtz",     48'h9000_0000_0000, 10'd254, 1'b0, 3'b001, 4'b0000, 32'h7F7F_FFFF, 5'b00101, 0, 1); drain();
        issue("ovf_rup_neg", 48'h9000_0000_0000, 10'd254, 1'b1, 3'b011, 4'b0000, 32'hFF7F_FFFF, 5'b00101, 0, 1); drain();
        issue("unf_zero",    48'h4000_0000_0000, 10'd0,   1'b1, 3'b000, 4'b0000, 32'h8000_0000, 5'b00011, 0, 1); drain();
        issue("unf_negexp",  48'h4000_0000_0000, 10'h3FB, 1'b0, 3'b000, 4'b0000, 32'h0000_0000, 5'b00011, 0, 1); drain();

        // Special operands
        issue("nan",         48'h4000_00C0_0000, 10'd127, 1'b0, 3'b000, 4'b1000, 32'h7FC0_0000, 5'b00000, 0, 1); drain();
        issue("snan",        48'h4000_00C0_0000, 10'd127, 1'b1, 3'b000, 4'b1001, 32'h7FC0_0000, 5'b10000, 0, 1); drain();
        issue("inf_x_zero",  48'h0,              10'd127, 1'b0, 3'b000, 4'b0111, 32'h7FC0_0000, 5'b10000, 0, 1); drain();
        issue("inf_neg",     48'h9000_0000_0000, 10'd254, 1'b1, 3'b000, 4'b0100, 32'hFF80_0000, 5'b00000, 0, 1); drain();
        issue("zero_neg",    48'h0,              10'd0,   1'b1, 3'b000, 4'b0010, 32'h8000_0000, 5'b00000, 0, 1); drain();

        // Clock enable held low for 5 cycles while in NORMALIZE
        issue("clken_stall", 48'h9000_0000_0000, 10'd127, 1'b0, 3'b000, 4'b0000, 32'h4010_0000, 5'b00000, 5, 1);
        clk_en_i = 1'b0;
        repeat (5) @(negedge clk_i);
        clk_en_i = 1'b1;
        drain();

        // Back-to-back products three cycles apart
        issue("b2b_a",       48'h9000_0000_0000, 10'd127, 1'b0, 3'b000, 4'b0000, 32'h4010_0000, 5'b00000, 0, 1);
        @(negedge clk_i);
        issue("b2b_b",       48'h4000_00C0_0000, 10'd127, 1'b0, 3'b001, 4'b0000, 32'h3F80_0001, 5'b00001, 0, 1);
        drain();

        // Reset asserted while in ROUND discards the operation
        issue("rst_victim",  48'h9000_0000_0000, 10'd254, 1'b0, 3'b000, 4'b0000, 32'h0, 5'b0, 0, 0);
        @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        chk("midrst_result", result_o, 32'h0);
        chk("midrst_ctrl", {30'h0, valid_o, busy_o}, 32'h0);
        chk("midrst_flags", {27'h0, flags_o}, 32'h0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (6) @(negedge clk_i);

        // Recovery after reset
        issue("post_rst",    48'h4000_00C0_0000, 10'd127, 1'b0, 3'b000, 4'b0000, 32'h3F80_0002, 5'b00001, 0, 1);
        drain();

        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results still outstanding, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
